// File: rtl/mu0_demux16.sv
// 16-bit 1-to-2 demultiplexer with a one-word valid/ready holding register per output channel.
// Optional per-channel delivery counters are built only when MU0_DEMUX_COUNT_EN is defined.
module mu0_demux16 (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] D,
    input  logic        S,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] A,
    output logic        a_valid,
    input  logic        a_ready,
    output logic [15:0] B,
    output logic        b_valid,
    input  logic        b_ready,
    output logic [7:0]  a_count,
    output logic [7:0]  b_count
);

    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        a_valid_q, a_valid_d;
    logic        b_valid_q, b_valid_d;
    logic        accept;
    logic        load_a, load_b;
    logic        a_hs, b_hs;

    always_comb begin
        in_ready = S ? (~b_valid_q | b_ready) : (~a_valid_q | a_ready);
        accept   = in_valid & in_ready;
        load_a   = accept & ~S;
        load_b   = accept & S;
        a_hs     = a_valid_q & a_ready;
        b_hs     = b_valid_q & b_ready;
    end

    // A load in the same cycle as a drain keeps the slot full with the new word.
    always_comb begin
        a_d       = load_a ? D : a_q;
        b_d       = load_b ? D : b_q;
        a_valid_d = load_a | (a_valid_q & ~a_hs);
        b_valid_d = load_b | (b_valid_q & ~b_hs);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q       <= 16'h0000;
            b_q       <= 16'h0000;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
        end
    end

    assign A       = a_q;
    assign B       = b_q;
    assign a_valid = a_valid_q;
    assign b_valid = b_valid_q;

`ifdef MU0_DEMUX_COUNT_EN
    logic [7:0] a_count_q, a_count_d;
    logic [7:0] b_count_q, b_count_d;

    always_comb begin
        a_count_d = a_hs ? a_count_q + 8'd1 : a_count_q;
        b_count_d = b_hs ? b_count_q + 8'd1 : b_count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_count_q <= 8'h00;
            b_count_q <= 8'h00;
        end else begin
            a_count_q <= a_count_d;
            b_count_q <= b_count_d;
        end
    end

    assign a_count = a_count_q;
    assign b_count = b_count_q;
`else
    assign a_count = 8'h00;
    assign b_count = 8'h00;
`endif

endmodule

// File: doc/mu0_demux16.md
MU0_DEMUX16 -- requirements
Module: mu0_demux16

Interface
REQ-001 SHALL have no parameters; data width fixed at 16 bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: D  input  16  data word from the producer.
REQ-005 SHALL have port: S  input  1  channel select; 0 = channel A, 1 = channel B.
REQ-006 SHALL have port: in_valid  input  1  producer has a word on D.
REQ-007 SHALL have port: in_ready  output  1  block accepts D this cycle.
REQ-008 SHALL have port: A  output  16  channel A data, registered.
REQ-009 SHALL have port: a_valid  output  1  A holds an undelivered word.
REQ-010 SHALL have port: a_ready  input  1  channel A consumer accepts A.
REQ-011 SHALL have port: B  output  16  channel B data, registered.
REQ-012 SHALL have port: b_valid  output  1  B holds an undelivered word.
REQ-013 SHALL have port: b_ready  input  1  channel B consumer accepts B.
REQ-014 SHALL have port: a_count  output  8  channel A delivered-word count.
REQ-015 SHALL have port: b_count  output  8  channel B delivered-word count.

Function
REQ-016 SHALL implement a 1-to-2 demultiplexer with a one-entry holding register per channel (states per channel: EMPTY when valid=0, FULL when valid=1).
REQ-017 SHALL drive in_ready combinationally: S=0 -> (~a_valid | a_ready); S=1 -> (~b_valid | b_ready).
REQ-018 SHALL accept a word only when in_valid & in_ready; S is ignored when in_valid=0.
REQ-019 SHALL load an accepted word into the selected channel register at the next rising edge and set that channel's valid (latency 1 cycle); the other channel SHALL be untouched.
REQ-020 SHALL clear a channel's valid on an output handshake (x_valid & x_ready) when no new word is loaded into that channel in the same cycle.
REQ-021 SHALL, on a simultaneous output handshake and load into the same channel, replace the data and keep valid=1 (full throughput, one word per cycle per channel).
REQ-022 SHALL hold A/B data and valid stable while valid=1 and ready=0.
REQ-023 SHALL impose no ordering between channels; the two channels drain independently.
REQ-024 SHALL leave A/B data unchanged when a channel empties (no clearing to zero).
REQ-025 SHALL increment a_count/b_count by 1 on each handshake of the respective output channel, wrapping 255 -> 0.

Reset
REQ-026 SHALL, while reset=1, asynchronously force A=16'h0000, B=16'h0000, a_valid=0, b_valid=0, a_count=0, b_count=0.
REQ-027 SHALL discard any held or in-flight word when reset asserts mid-operation; in_ready follows REQ-017 from the cleared valids.
REQ-028 SHALL resume accepting words at the first rising edge after reset deasserts.

Configuration
REQ-029 SHALL compile the delivery counters only when macro MU0_DEMUX_COUNT_EN is defined; with it, a_count/b_count behave per REQ-025.
REQ-030 SHALL, without MU0_DEMUX_COUNT_EN, keep ports a_count/b_count present but tied to 8'h00, with no counter registers.

Verification
REQ-031 Reset: assert reset mid-transfer with a_valid=1 -> A=0000, a_valid=0, b_valid=0, counts=0 immediately, without a clock edge.
REQ-032 Steering: D=1234, S=0, in_valid=1 for one cycle -> next cycle A=1234, a_valid=1, b_valid=0, B unchanged.
REQ-033 Backpressure: a_valid=1, a_ready=0, S=0, in_valid=1 -> in_ready=0, A held; with S=1 in the same state -> in_ready=1, word loads into B.
REQ-034 Throughput: a_ready=1, S=0, stream D=0001..0005 back-to-back -> A shows 0001..0005 on consecutive cycles, a_valid continuously 1, a_count=5 (with MU0_DEMUX_COUNT_EN).
REQ-035 Wrap: 256 handshakes on channel B with MU0_DEMUX_COUNT_EN -> b_count returns to 00; without the macro -> a_count=b_count=00 throughout.
